id_stage: RTL

Parametrised instruction-decode stage for the MIPS pipeline. It decodes R-type and I-type logic/arithmetic/memory instructions and resolves rs/rt operands through a configurable number of priority-ordered bypass ports. Load-use interlocks stall the stage until the operand data is available. Results go into a registered ID/EX pipeline slot with valid/ready handshake and flush. It sits between the IF/ID register plus register file and the EX stage.

---
 rtl/id_pkg.sv | 128 ++++++++++++
 rtl/id_fwd_mux.sv | 39 +++
 rtl/id_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/id_pkg.sv
// Shared decode constants and the instruction decoder for the MIPS ID stage.
// Operand resolution and slot registering live in id_fwd_mux / id_stage.
package id_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_ADDIU   = 6'b001001;
   localparam logic [5:0] OP_SLTI    = 6'b001010;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;

   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   localparam logic [2:0] ALUSEL_NOP   = 3'b000;
   localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
   localparam logic [2:0] ALUSEL_ARITH = 3'b010;
   localparam logic [2:0] ALUSEL_MEM   = 3'b011;

   localparam logic [7:0] ALUOP_NOP  = 8'h00;
   localparam logic [7:0] ALUOP_AND  = 8'h24;
   localparam logic [7:0] ALUOP_OR   = 8'h25;
   localparam logic [7:0] ALUOP_XOR  = 8'h26;
   localparam logic [7:0] ALUOP_NOR  = 8'h27;
   localparam logic [7:0] ALUOP_ADDU = 8'h21;
   localparam logic [7:0] ALUOP_SUBU = 8'h23;
   localparam logic [7:0] ALUOP_SLT  = 8'h2a;
   localparam logic [7:0] ALUOP_LW   = 8'he3;
   localparam logic [7:0] ALUOP_SW   = 8'heb;

   typedef enum logic [1:0] {
      IMM_ZERO = 2'd0,
      IMM_SIGN = 2'd1,
      IMM_LUI  = 2'd2
   } imm_kind_t;

   typedef struct packed {
      logic [2:0] alusel;
      logic [7:0] aluop;
      logic       rs_en;
      logic       rt_en;
      logic       use_rt;
      logic       use_imm;
      imm_kind_t  imm_kind;
      logic [4:0] wd;
      logic       wreg;
      logic       mem_rd;
      logic       mem_wr;
      logic       illegal;
   } dec_t;

   function automatic dec_t decode(input logic [31:0] inst);
      dec_t d;
      d = '0;
      d.imm_kind = IMM_ZERO;
      if (inst[31:26] == OP_SPECIAL) begin
         d.rs_en  = 1'b1;
         d.rt_en  = 1'b1;
         d.use_rt = 1'b1;
         d.wd     = inst[15:11];
         d.wreg   = 1'b1;
         case (inst[5:0])
            FN_AND:  {d.alusel, d.aluop} = {ALUSEL_LOGIC, ALUOP_AND};
            FN_OR:   {d.alusel, d.aluop} = {ALUSEL_LOGIC, ALUOP_OR};
            FN_XOR:  {d.alusel, d.aluop} = {ALUSEL_LOGIC, ALUOP_XOR};
            FN_NOR:  {d.alusel, d.aluop} = {ALUSEL_LOGIC, ALUOP_NOR};
            FN_ADDU: {d.alusel, d.aluop} = {ALUSEL_ARITH, ALUOP_ADDU};
            FN_SUBU: {d.alusel, d.aluop} = {ALUSEL_ARITH, ALUOP_SUBU};
            FN_SLT:  {d.alusel, d.aluop} = {ALUSEL_ARITH, ALUOP_SLT};
            default: d.illegal = 1'b1;
         endcase
      end else begin
         d.rs_en   = 1'b1;
         d.use_imm = 1'b1;
         d.wd      = inst[20:16];
         d.wreg    = 1'b1;
         case (inst[31:26])
            OP_ANDI:  {d.alusel, d.aluop} = {ALUSEL_LOGIC, ALUOP_AND};
            OP_ORI:   {d.alusel, d.aluop} = {ALUSEL_LOGIC, ALUOP_OR};
            OP_XORI:  {d.alusel, d.aluop} = {ALUSEL_LOGIC, ALUOP_XOR};
            OP_LUI: begin
               {d.alusel, d.aluop} = {ALUSEL_LOGIC, ALUOP_OR};
               d.rs_en    = 1'b0;
               d.imm_kind = IMM_LUI;
            end
            OP_ADDIU: begin
               {d.alusel, d.aluop} = {ALUSEL_ARITH, ALUOP_ADDU};
               d.imm_kind = IMM_SIGN;
            end
            OP_SLTI: begin
               {d.alusel, d.aluop} = {ALUSEL_ARITH, ALUOP_SLT};
               d.imm_kind = IMM_SIGN;
            end
            OP_LW: begin
               {d.alusel, d.aluop} = {ALUSEL_MEM, ALUOP_LW};
               d.imm_kind = IMM_SIGN;
               d.mem_rd   = 1'b1;
            end
            OP_SW: begin
               {d.alusel, d.aluop} = {ALUSEL_MEM, ALUOP_SW};
               d.imm_kind = IMM_SIGN;
               d.rt_en    = 1'b1;
               d.mem_wr   = 1'b1;
               d.wd       = 5'd0;
               d.wreg     = 1'b0;
            end
            default: d.illegal = 1'b1;
         endcase
      end
      if (d.wd == 5'd0) d.wreg = 1'b0;
      // Unsupported encodings still travel down the pipe, but as a pure no-op.
      if (d.illegal) begin
         d = '0;
         d.imm_kind = IMM_ZERO;
         d.illegal  = 1'b1;
      end
      return d;
   endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Resolves one register operand against the bypass ports (port 0 = youngest).
// A pending winner means the value is not ready yet and raises a hazard.
module id_fwd_mux
   import id_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NUM_FWD = 2
) (
   input  logic [4:0]                addr,
   input  logic                      read_en,
   input  logic [DATA_W-1:0]         rf_data,
   input  logic [NUM_FWD-1:0]        fwd_wreg,
   input  logic [5*NUM_FWD-1:0]      fwd_wd,
   input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata,
   input  logic [NUM_FWD-1:0]        fwd_pending,
   output logic [DATA_W-1:0]         data,
   output logic                      hazard
);

   logic found;

   always_comb begin
      data   = rf_data;
      hazard = 1'b0;
      found  = 1'b0;
      for (int i = 0; i < NUM_FWD; i++) begin
         if (!found && fwd_wreg[i] && (fwd_wd[5*i +: 5] == addr)) begin
            found  = 1'b1;
            data   = fwd_wdata[DATA_W*i +: DATA_W];
            hazard = fwd_pending[i];
         end
      end
      if (!read_en || (addr == 5'd0)) begin
         data   = '0;
         hazard = 1'b0;
      end
   end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decode, bypass resolution, load-use interlock
// and a registered ID/EX slot.
module id_stage
   import id_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int NUM_FWD     = 2,
   parameter int STALL_CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               pc_i,
   input  logic [31:0]               inst_i,
   input  logic [DATA_W-1:0]         reg1_data_i,
   input  logic [DATA_W-1:0]         reg2_data_i,
   output logic [4:0]                reg1_addr_o,
   output logic [4:0]                reg2_addr_o,
   input  logic [NUM_FWD-1:0]        fwd_wreg_i,
   input  logic [5*NUM_FWD-1:0]      fwd_wd_i,
   input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata_i,
   input  logic [NUM_FWD-1:0]        fwd_pending_i,
   input  logic                      flush_i,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2:0]                alusel_o,
   output logic [7:0]                aluop_o,
   output logic [DATA_W-1:0]         reg1_o,
   output logic [DATA_W-1:0]         reg2_o,
   output logic [DATA_W-1:0]         store_data_o,
   output logic [4:0]                wd_o,
   output logic                      wreg_o,
   output logic                      mem_rd_o,
   output logic                      mem_wr_o,
   output logic [31:0]               pc_o,
   output logic                      illegal_o,
   output logic [STALL_CNT_W-1:0]    stall_cnt_o
);

   dec_t              dec;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] rs_data, rt_data;
   logic              rs_hazard, rt_hazard;
   logic              hazard, accept;
   logic [DATA_W-1:0] reg2_next, store_next;

   assign dec         = decode(inst_i);
   assign reg1_addr_o = inst_i[25:21];
   assign reg2_addr_o = inst_i[20:16];

   always_comb begin
      case (dec.imm_kind)
         IMM_SIGN: imm_ext = DATA_W'($signed(inst_i[15:0]));
         IMM_LUI:  imm_ext = DATA_W'({inst_i[15:0], 16'h0000});
         default:  imm_ext = DATA_W'(inst_i[15:0]);
      endcase
   end

   id_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_rs_mux (
      .addr        (inst_i[25:21]),
      .read_en     (dec.rs_en),
      .rf_data     (reg1_data_i),
      .fwd_wreg    (fwd_wreg_i),
      .fwd_wd      (fwd_wd_i),
      .fwd_wdata   (fwd_wdata_i),
      .fwd_pending (fwd_pending_i),
      .data        (rs_data),
      .hazard      (rs_hazard)
   );

   id_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_rt_mux (
      .addr        (inst_i[20:16]),
      .read_en     (dec.rt_en),
      .rf_data     (reg2_data_i),
      .fwd_wreg    (fwd_wreg_i),
      .fwd_wd      (fwd_wd_i),
      .fwd_wdata   (fwd_wdata_i),
      .fwd_pending (fwd_pending_i),
      .data        (rt_data),
      .hazard      (rt_hazard)
   );

   // Handshake: an instruction transfers on a cycle where valid && ready are both
   // high on the same side; valid never depends on ready, and a held slot is stable.
   assign hazard   = in_valid && (rs_hazard || rt_hazard);
   assign in_ready = !hazard && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   assign reg2_next  = dec.use_rt ? rt_data : (dec.use_imm ? imm_ext : '0);
   assign store_next = dec.mem_wr ? rt_data : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid    <= 1'b0;
         alusel_o     <= '0;
         aluop_o      <= '0;
         reg1_o       <= '0;
         reg2_o       <= '0;
         store_data_o <= '0;
         wd_o         <= '0;
         wreg_o       <= 1'b0;
         mem_rd_o     <= 1'b0;
         mem_wr_o     <= 1'b0;
         pc_o         <= '0;
         illegal_o    <= 1'b0;
      end else if (flush_i) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         alusel_o     <= dec.alusel;
         aluop_o      <= dec.aluop;
         reg1_o       <= rs_data;
         reg2_o       <= reg2_next;
         store_data_o <= store_next;
         wd_o         <= dec.wd;
         wreg_o       <= dec.wreg;
         mem_rd_o     <= dec.mem_rd;
         mem_wr_o     <= dec.mem_wr;
         pc_o         <= pc_i;
         illegal_o    <= dec.illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_o <= '0;
      end else if (hazard && !flush_i && (stall_cnt_o != '1)) begin
         stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
      end
   end

endmodule
